// File: rtl/pwm_fade_sequencer.sv
// rtl/pwm_fade_sequencer.sv - multi-channel PWM fade engine with shared triangle/sawtooth level
module pwm_fade_sequencer #(
  parameter int CHANNELS = 3,
  parameter int DUTY_W   = 8,
  parameter int STEP_DIV = 100,
  parameter int PHASE    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [DUTY_W-1:0]   static_duty,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [DUTY_W-1:0]   level,
  output logic                cycle_done
);

  localparam logic [DUTY_W-1:0] MAX      = '1;
  localparam int                PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(STEP_DIV - 1);

  typedef enum logic {RISE, FALL} state_t;

  state_t              state;
  logic [1:0]          mode_q;
  logic [PRE_W-1:0]    prescaler;
  logic [DUTY_W-1:0]   pwm_cnt;
  logic [DUTY_W-1:0]   shadow [CHANNELS];
  logic [DUTY_W-1:0]   target [CHANNELS];
  logic [DUTY_W+3:0]   level_ext;
  logic                tick;
  logic                ramp;

  assign tick      = (prescaler == PRE_LAST);
  assign ramp      = (mode_q == 2'd1) || (mode_q == 2'd2);
  assign level_ext = {4'b0000, level};

  // Lag is subtracted in a widened domain so a large lag clamps to zero instead of wrapping.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      target[i] = '0;
      if (mode_q == 2'd3)
        target[i] = static_duty;
      else if (ramp && (level_ext > (DUTY_W+4)'(i * PHASE)))
        target[i] = DUTY_W'(level_ext - (DUTY_W+4)'(i * PHASE));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RISE;
      mode_q     <= 2'd0;
      prescaler  <= '0;
      level      <= '0;
      cycle_done <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      if (mode != mode_q) begin
        mode_q    <= mode;
        state     <= RISE;
        prescaler <= '0;
        level     <= '0;
      end else if (enable) begin
        prescaler <= tick ? '0 : prescaler + 1'b1;
        if (tick && ramp) begin
          if (mode_q == 2'd2) begin
            state <= RISE;
            if (level == MAX) begin
              level      <= '0;
              cycle_done <= 1'b1;
            end else begin
              level <= level + 1'b1;
            end
          end else if (state == RISE) begin
            level <= level + 1'b1;
            if (level == MAX - 1'b1)
              state <= FALL;
          end else begin
            level <= level - 1'b1;
            if (level == {{(DUTY_W-1){1'b0}}, 1'b1}) begin
              state      <= RISE;
              cycle_done <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Shadows only reload on the last count of a period, so every period is a whole pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
      pwm_out <= '0;
      for (int i = 0; i < CHANNELS; i++)
        shadow[i] <= '0;
    end else if (enable) begin
      pwm_cnt <= pwm_cnt + 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_out[i] <= (pwm_cnt < shadow[i]);
        if (pwm_cnt == MAX)
          shadow[i] <= target[i];
      end
    end else begin
      pwm_out <= '0;
    end
  end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// tb/tb_pwm_fade_sequencer.sv - table, directed and random checks against a tick-count reference model
module tb_pwm_fade_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] mode;
  logic [3:0] static_duty;
  logic [2:0] pwm_out;
  logic [3:0] level;
  logic       cycle_done;

  pwm_fade_sequencer #(.CHANNELS(3), .DUTY_W(4), .STEP_DIV(2), .PHASE(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .static_duty(static_duty),
    .pwm_out(pwm_out), .level(level), .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cd_seen;

  // Reference model: level is a pure function of enabled clocks since the last mode change.
  int         k, mm, pc;
  int         sh [3];
  logic [2:0] pm;
  logic       cdm;

  function automatic int mlevel();
    int p;
    if (mm == 1) begin
      p = (k / 2) % 30;
      return (p <= 15) ? p : 30 - p;
    end
    if (mm == 2) return (k / 2) % 16;
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int lv, t;
    int tg [3];
    if (reset) begin
      k = 0; mm = 0; pc = 0; pm = '0; cdm = 1'b0;
      for (int i = 0; i < 3; i++) sh[i] = 0;
    end else begin
      lv  = mlevel();
      cdm = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (mm == 3) tg[i] = static_duty;
        else if ((mm == 1 || mm == 2) && lv > i * 4) tg[i] = lv - i * 4;
        else tg[i] = 0;
      end
      if (int'(mode) != mm) begin
        mm = mode;
        k  = 0;
      end else if (enable) begin
        k++;
        if ((mm == 1 || mm == 2) && (k % 2 == 0)) begin
          t = k / 2;
          if (t % ((mm == 1) ? 30 : 16) == 0) cdm = 1'b1;
        end
      end
      if (enable) begin
        for (int i = 0; i < 3; i++) pm[i] = (pc < sh[i]);
        if (pc == 15)
          for (int i = 0; i < 3; i++) sh[i] = tg[i];
        pc = (pc + 1) % 16;
      end else begin
        pm = '0;
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("level", level, mlevel());
    check("pwm_out", pwm_out, pm);
    check("cycle_done", cycle_done, cdm);
    if (cycle_done) cd_seen++;
  endtask

  task automatic count_high(input int exp);
    int cnt [3];
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    for (int c = 0; c < 16; c++) begin
      cyc();
      for (int i = 0; i < 3; i++) cnt[i] += pwm_out[i];
    end
    for (int i = 0; i < 3; i++) check("high_count", cnt[i], exp);
  endtask

  typedef struct {
    logic       en;
    logic [1:0] md;
    logic [3:0] sd;
    int         n;
    int         lvl;
    logic       chk_pwm;
    logic [2:0] pw;
    int         cds;
  } vec_t;

  vec_t vt [12];

  initial begin
    int   cnt0;
    logic found;
    logic prev;

    vt[0]  = '{1'b1, 2'd0, 4'd0,  100,  0, 1'b1, 3'b000, 0};
    vt[1]  = '{1'b1, 2'd1, 4'd0,   31, 15, 1'b0, 3'b000, 0};
    vt[2]  = '{1'b1, 2'd1, 4'd0,   30,  0, 1'b0, 3'b000, 1};
    vt[3]  = '{1'b1, 2'd1, 4'd0,   20, 10, 1'b0, 3'b000, 0};
    vt[4]  = '{1'b0, 2'd1, 4'd0,   40, 10, 1'b1, 3'b000, 0};
    vt[5]  = '{1'b1, 2'd1, 4'd0,    6, 13, 1'b0, 3'b000, 0};
    vt[6]  = '{1'b1, 2'd2, 4'd0,    1,  0, 1'b0, 3'b000, 0};
    vt[7]  = '{1'b1, 2'd2, 4'd0,   29, 14, 1'b0, 3'b000, 0};
    vt[8]  = '{1'b1, 2'd2, 4'd0,    2, 15, 1'b0, 3'b000, 0};
    vt[9]  = '{1'b1, 2'd2, 4'd0,    2,  0, 1'b0, 3'b000, 1};
    vt[10] = '{1'b1, 2'd3, 4'd15,  40,  0, 1'b0, 3'b000, 0};
    vt[11] = '{1'b1, 2'd0, 4'd15,  20,  0, 1'b1, 3'b000, 0};

    reset = 1'b1; enable = 1'b0; mode = 2'd0; static_duty = 4'd0;
    cyc(); cyc();
    check("reset_level", level, 0);
    check("reset_pwm", pwm_out, 0);
    reset = 1'b0;

    for (int e = 0; e < 12; e++) begin
      enable = vt[e].en; mode = vt[e].md; static_duty = vt[e].sd;
      cd_seen = 0;
      repeat (vt[e].n) cyc();
      check("vec_level", level, vt[e].lvl);
      if (vt[e].chk_pwm) check("vec_pwm", pwm_out, vt[e].pw);
      check("vec_cycle_done_count", cd_seen, vt[e].cds);
    end

    // Reset pulse in the middle of a rising ramp.
    enable = 1'b1; mode = 2'd1;
    repeat (25) cyc();
    check("ramp_before_reset", level, 12);
    reset = 1'b1;
    cyc();
    check("reset_mid_level", level, 0);
    check("reset_mid_cd", cycle_done, 0);
    cyc();
    check("reset_mid_pwm", pwm_out, 0);
    reset = 1'b0;

    // Static duties: whole-period high counts.
    mode = 2'd3;
    static_duty = 4'd0;  repeat (40) cyc(); count_high(0);
    static_duty = 4'd15; repeat (40) cyc(); count_high(15);
    static_duty = 4'd5;  repeat (40) cyc(); count_high(5);

    // Change 5 -> 12 mid-period; the running period must stay at 5.
    found = 1'b0;
    prev  = pwm_out[0];
    for (int c = 0; c < 40 && !found; c++) begin
      cyc();
      if (pwm_out[0] && !prev) found = 1'b1;
      prev = pwm_out[0];
    end
    check("rise_found", found, 1);
    cnt0 = 1;
    for (int j = 0; j < 15; j++) begin
      if (j == 7) static_duty = 4'd12;
      cyc();
      cnt0 += pwm_out[0];
    end
    check("mid_period_old_duty", cnt0, 5);
    count_high(12);

    // Randomized segments against the model.
    for (int s = 0; s < 200; s++) begin
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1; cyc(); reset = 1'b0;
      end
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
      static_duty = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 60)) cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_fade_sequencer.md
# pwm_fade_sequencer

Parametrised multi-channel PWM fade engine for LED drivers. One shared level ramps through triangle (breathing) or sawtooth profiles at a programmable step rate. Each channel gets a phase-lagged copy of that level and drives one glitch-free PWM output. It sits between the board LED pins and control logic that supplies `mode`, `enable` and `static_duty`.

## Interface
- `CHANNELS`, 3: number of PWM outputs (1..8).
- `DUTY_W`, 8: duty/PWM resolution; PWM period = 2^DUTY_W clocks; MAX = 2^DUTY_W-1.
- `STEP_DIV`, 100: clocks per level step (>=1).
- `PHASE`, 16: per-channel level lag in duty units; channel i lags by i*PHASE.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  1 = run; 0 = freeze counters and force outputs low.
- `mode`  in  2  0 off, 1 triangle, 2 sawtooth, 3 static.
- `static_duty`  in  DUTY_W  duty used by all channels in static mode.
- `pwm_out`  out  CHANNELS  registered PWM outputs.
- `level`  out  DUTY_W  current shared level.
- `cycle_done`  out  1  one-clock pulse at the end of each full fade cycle.

## Operation
- Reset: `pwm_out`=0, `level`=0, `cycle_done`=0, state=RISE, prescaler=0, pwm_cnt=0, shadow duties=0, mode_q=0.
- pwm_cnt: DUTY_W-bit free-running counter, wraps MAX->0.
- Prescaler: counts 0..STEP_DIV-1. `tick` is asserted when it equals STEP_DIV-1, then it returns to 0.
- FSM states are RISE and FALL. It acts only on `tick` when `enable`=1 and mode is 1 or 2.
  - Triangle, RISE: level+1. When the new level is MAX, go to FALL.
  - Triangle, FALL: level-1. When the new level is 0, go to RISE and pulse `cycle_done`.
  - Sawtooth: always RISE. level+1 while level<MAX. Level MAX wraps to 0 and pulses `cycle_done`.
  - Off (0) and static (3): level holds; FSM idle.
- Mode change: the cycle after `mode`≠mode_q, level=0, state=RISE, prescaler=0, and mode_q←mode. No `cycle_done` pulse. pwm_cnt is not reset.
- Channel target duty:
  - mode 1/2: duty_i = level − i*PHASE if level > i*PHASE, else 0. Compute at DUTY_W+4 bits with no wrap.
  - mode 3: duty_i = `static_duty` for every channel, no phase lag.
  - mode 0: duty_i = 0.
- Shadow duty: the target is latched into shadow_i only when pwm_cnt==MAX. Duty changes therefore take effect at PWM period boundaries, with no runt pulses.
- Output: `pwm_out[i]` ← (pwm_cnt < shadow_i), registered.
  - Duty 0 gives a constant low output.
  - Duty MAX gives high for MAX of 2^DUTY_W clocks, so the output never reaches 100%.
- `enable`=0: prescaler, pwm_cnt, level and FSM are frozen. `pwm_out` is forced to 0 on the next clock. `cycle_done`=0. Re-enable resumes from the frozen state.
- Priority: reset > mode change > enable=0 > tick.

## Timing
- `tick` first asserts STEP_DIV clocks after reset release while enabled in mode 1/2. `level` updates on the clock after the tick cycle and is registered.
- `cycle_done` is registered and coincides with the level update that completes the cycle.
- Full triangle cycle = 2*MAX*STEP_DIV clocks. Full sawtooth cycle = (MAX+1)*STEP_DIV clocks.
- Level-to-output latency: up to 2^DUTY_W clocks for the shadow latch, plus 1 clock for the output register.
- A tick and pwm_cnt==MAX in the same cycle: the shadow latches the pre-update level. The new level applies at the next boundary.
- Reset asserted mid-ramp: all state returns to reset values on the next edge. Outputs are low one clock later.

## Test plan
Parameters: CHANNELS=3, DUTY_W=4, STEP_DIV=2, PHASE=4.

- Reset, then idle in mode 0 for 100 clocks -> `pwm_out`=000, `level`=0, `cycle_done` never asserts.
- Mode 1, enable=1 -> `level` reaches 15 at about 30 clocks and returns to 0 at about 60 clocks. Exactly one `cycle_done` pulse, coincident with level 0. The pattern repeats with a 60-clock period.
- Mode 1, sampled at level=10 -> shadows are 10/6/2. Within one 16-clock PWM period, pwm_out[0..2] are high for 10/6/2 clocks. At level=3, channels 1 and 2 stay low.
- Mode 2 -> `level` steps 14, 15, 0 with `cycle_done` on the 15→0 step. `level` never decrements. The period is 32 clocks.
- Mode 3 with `static_duty`=0 -> all outputs stay low. With `static_duty`=15 -> each output is high 15 of every 16 clocks. A change from 5 to 12 in the middle of a PWM period takes effect only after pwm_cnt==15.
- Mid-ramp checks:
  - enable=0 for 40 clocks -> outputs low and `level` frozen; on re-enable the ramp resumes from the same level.
  - Switching mode 1→2 -> `level`=0 with no `cycle_done`.
  - reset pulse -> all outputs at reset values.
